mem_dump_unit: RTL and testbench

MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

---
 rtl/mem_dump_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_dump_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: reads DUMP_WORDS words from data memory and streams each to a UART, MSB byte first.
// Defining MEM_DUMP_HEADER_EN prepends a single 0xA5 header byte to every run.
module mem_dump_unit #(
  parameter int MEM_SIZE    = 1024,
  parameter int DUMP_WORDS  = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int DATA_LENGTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic [ADDR_LENGTH-1:0] o_mem_addr,
  output logic                   o_mem_re,
  input  logic [DATA_LENGTH-1:0] i_mem_data,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int WCW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(DUMP_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd2,
    ST_LATCH   = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5,
    ST_DONE    = 3'd6
`ifdef MEM_DUMP_HEADER_EN
    , ST_HDR   = 3'd1
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [WCW-1:0]         word_cnt_q, word_cnt_d;
  logic [WCW-1:0]         word_inc;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [31:0]            shift_q, shift_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic                   re_q, re_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state logic; outputs are computed one cycle ahead so each is high exactly while its state is current
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    re_d       = 1'b0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    word_inc   = word_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          word_cnt_d = {WCW{1'b0}};
          busy_d     = 1'b1;
`ifdef MEM_DUMP_HEADER_EN
          state_d    = ST_HDR;
          tx_data_d  = 8'hA5;
          tx_start_d = 1'b1;
`else
          state_d    = ST_ADDR;
          addr_d     = {ADDR_LENGTH{1'b0}};
          re_d       = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef MEM_DUMP_HEADER_EN
      ST_HDR: begin
        if (i_tx_done) begin
          state_d = ST_ADDR;
          addr_d  = ADDR_LENGTH'(word_cnt_q);
          re_d    = 1'b1;
        end else begin
          state_d = ST_HDR;
        end
      end
`endif
      ST_ADDR: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        shift_d    = i_mem_data[31:0];
        byte_cnt_d = 2'd0;
        tx_data_d  = i_mem_data[31:24];
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          shift_d    = {shift_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // byte_cnt_q is the index of the byte just finished; 3 means the word is complete
          if (byte_cnt_q != 2'd3) begin
            state_d    = ST_SEND;
            tx_data_d  = shift_q[23:16];
            tx_start_d = 1'b1;
          end else if (word_cnt_q < LAST_WORD) begin
            word_cnt_d = word_inc;
            addr_d     = ADDR_LENGTH'(word_inc);
            re_d       = 1'b1;
            state_d    = ST_ADDR;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_WAIT_TX;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= {WCW{1'b0}};
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'h0000_0000;
      addr_q     <= {ADDR_LENGTH{1'b0}};
      re_q       <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      re_q       <= re_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_mem_addr = addr_q;
  assign o_mem_re   = re_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Testbench for mem_dump_unit: cycle-exact vector table on a 2-word instance plus UART-model
// sequences (stall, ignored inputs, mid-run reset) and a full 1024-word boundary run.
`timescale 1ns/1ps
module tb_mem_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: 2 words
  logic        rst, start, tx_done;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_data = 32'h0000_0000;
  logic [7:0]  tx_data;
  logic        tx_start, busy, done;

  mem_dump_unit #(.MEM_SIZE(1024), .DUMP_WORDS(2), .ADDR_LENGTH(32), .DATA_LENGTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_mem_addr(mem_addr), .o_mem_re(mem_re), .i_mem_data(mem_data),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_done(done)
  );

  // Boundary instance: DUMP_WORDS = MEM_SIZE = 1024
  logic        b_rst, b_start, b_tx_done;
  logic [31:0] b_mem_addr;
  logic        b_mem_re;
  logic [31:0] b_mem_data = 32'h0000_0000;
  logic [7:0]  b_tx_data;
  logic        b_tx_start, b_busy, b_done;

  mem_dump_unit #(.MEM_SIZE(1024), .DUMP_WORDS(1024), .ADDR_LENGTH(32), .DATA_LENGTH(32)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start),
    .o_mem_addr(b_mem_addr), .o_mem_re(b_mem_re), .i_mem_data(b_mem_data),
    .o_tx_data(b_tx_data), .o_tx_start(b_tx_start), .i_tx_done(b_tx_done),
    .o_busy(b_busy), .o_done(b_done)
  );

  // Synchronous-read memories with one cycle of latency
  always @(posedge clk) begin
    if (mem_re) begin
      case (mem_addr)
        32'd0:   mem_data <= 32'h1122_3344;
        32'd1:   mem_data <= 32'hAABB_CCDD;
        default: mem_data <= 32'hDEAD_BEEF;
      endcase
    end
    if (b_mem_re) b_mem_data <= 32'hC0DE_0000 | b_mem_addr;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, start, txd;
    logic        busy, done, ts, re;
    logic [31:0] addr;
    logic [7:0]  data;
  } vec_t;
  vec_t vecs [28];

  logic [7:0] exp_bytes [8];
  logic [7:0] got [$];
  int  done_cnt, uart_cnt, ts_cnt;
  bit  stall, pend, prev_ts, prev_re, inj_latch;

  task automatic reset_model();
    got.delete();
    done_cnt = 0; uart_cnt = 0; ts_cnt = 0;
    stall = 1'b0; pend = 1'b0; prev_ts = 1'b0; prev_re = 1'b0; inj_latch = 1'b0;
  endtask

  // One clock; pulses are cleared, then the UART model answers 3 cycles after each tx_start
  task automatic step();
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0; tx_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) pend = 1'b1;
    end
    if (pend && !stall) begin
      tx_done = 1'b1;
      pend = 1'b0;
    end
    if (tx_start) begin
      checks++;
      if (prev_ts) begin
        errors++;
        $display("FAIL tx_start_b2b actual=1 expected=0");
      end
      got.push_back(tx_data);
      ts_cnt++;
      uart_cnt = 3;
    end
    if (inj_latch && prev_re && !mem_re) tx_done = 1'b1;
    if (done) done_cnt++;
    prev_ts = tx_start;
    prev_re = mem_re;
  endtask

  task automatic wait_ts(input int n, input string name);
    for (int i = 0; i < 200 && ts_cnt < n; i++) step();
    check(name, 64'(ts_cnt >= n), 64'd1);
  endtask

  task automatic run_until_done(input string name);
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    for (int i = 0; i < 10; i++) step();
    check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    check({name, "_nbytes"}, 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check($sformatf("%s_byte%0d", name, i), 64'(got[i]), 64'(exp_bytes[i]));
  endtask

  int          b_bytes, b_res, b_uart, b_guard;
  logic [31:0] b_last_addr, b_max_addr;
  logic [31:0] b_last4;
  bit          b_got_done;
  int          bad;

  initial begin
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    //          rst   start txd   busy  done  ts    re    addr   data
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 8'h11};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'h11};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 8'h22};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'h22};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'h22};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 8'h33};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'h33};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 8'h44};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'h44};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 8'h44};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 8'h44};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 8'hAA};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 8'hAA};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 8'hBB};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 8'hBB};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 8'hCC};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 8'hCC};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 8'hDD};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 8'hDD};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 8'hDD};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 8'hDD};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 8'hDD};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00};

    rst = 1'b1; start = 1'b0; tx_done = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_tx_done = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;

    // Cycle-exact table: each row's inputs are applied for one edge, outputs sampled 1ns later
    for (int i = 0; i < 28; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; tx_done = vecs[i].txd;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            64'({busy, done, tx_start, mem_re, mem_addr, tx_data}),
            64'({vecs[i].busy, vecs[i].done, vecs[i].ts, vecs[i].re, vecs[i].addr, vecs[i].data}));
    end
    rst = 1'b0; start = 1'b0; tx_done = 1'b0;

    // Basic dump with the UART model
    reset_model();
    start = 1'b1;
    step();
    run_until_done("basic");

    // Stalled UART: no reply for 100 cycles after the first byte
    reset_model();
    stall = 1'b1;
    start = 1'b1;
    step();
    wait_ts(1, "stall_first_ts");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx_data !== 8'h11 || busy !== 1'b1) bad++;
    end
    check("stall_hold_outputs", 64'(bad), 64'd0);
    check("stall_no_second_ts", 64'(ts_cnt), 64'd1);
    stall = 1'b0;
    run_until_done("stall");

    // Ignored inputs: i_start during WAIT_TX of byte 2, spurious i_tx_done in LATCH
    reset_model();
    inj_latch = 1'b1;
    start = 1'b1;
    step();
    wait_ts(2, "ign_second_ts");
    step();
    start = 1'b1;
    step();
    run_until_done("ignored");

    // Reset one cycle after the 5th byte's tx_start, then a fresh run
    reset_model();
    start = 1'b1;
    step();
    wait_ts(5, "rst_fifth_ts");
    rst = 1'b1;
    step();
    check("rst_outputs_zero", 64'({busy, done, tx_start, mem_re, mem_addr, tx_data}), 64'd0);
    reset_model();
    for (int i = 0; i < 30; i++) step();
    check("rst_no_ts_after", 64'(ts_cnt), 64'd0);
    check("rst_no_done_after", 64'(done_cnt), 64'd0);
    start = 1'b1;
    step();
    run_until_done("restart");

    // Boundary: 1024-word dump
    b_rst = 1'b0;
    @(posedge clk); #1;
    b_start = 1'b1;
    b_bytes = 0; b_res = 0; b_uart = 0; b_guard = 0;
    b_last_addr = 32'd0; b_max_addr = 32'd0; b_last4 = 32'd0; b_got_done = 1'b0;
    while (!b_got_done && b_guard < 40000) begin
      @(posedge clk); #1;
      b_guard++;
      b_start = 1'b0;
      b_tx_done = 1'b0;
      if (b_uart > 0) begin
        b_uart--;
        if (b_uart == 0) b_tx_done = 1'b1;
      end
      if (b_tx_start) begin
        b_bytes++;
        b_last4 = {b_last4[23:0], b_tx_data};
        b_uart = 3;
      end
      if (b_mem_re) begin
        b_res++;
        b_last_addr = b_mem_addr;
        if (b_mem_addr > b_max_addr) b_max_addr = b_mem_addr;
      end
      if (b_done) b_got_done = 1'b1;
    end
    check("bnd_done", 64'(b_got_done), 64'd1);
    check("bnd_bytes", 64'(b_bytes), 64'd4096);
    check("bnd_reads", 64'(b_res), 64'd1024);
    check("bnd_last_addr", 64'(b_last_addr), 64'd1023);
    check("bnd_max_addr", 64'(b_max_addr), 64'd1023);
    check("bnd_last_word_bytes", 64'(b_last4), 64'hC0DE_03FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
